// File: rtl/ft245_pkg.sv
// Shared constants for the FT245 transmit framer: state encoding and default sync bytes.
// FT245_TX_FRAMER_CHECKSUM_EN adds the CHK state used by the trailing checksum byte.
package ft245_pkg;

    localparam logic [7:0] DEF_HDR0 = 8'hA5;
    localparam logic [7:0] DEF_HDR1 = 8'h5A;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_HDR        = 3'd1;
    localparam logic [2:0] ST_LEN        = 3'd2;
    localparam logic [2:0] ST_WORD_WAIT  = 3'd3;
    localparam logic [2:0] ST_BYTE_ISSUE = 3'd4;
    localparam logic [2:0] ST_BYTE_WAIT  = 3'd5;
    localparam logic [2:0] ST_DONE       = 3'd6;
    localparam logic [2:0] ST_CHK        = 3'd7;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        HDR        = ST_HDR,
        LEN        = ST_LEN,
        WORD_WAIT  = ST_WORD_WAIT,
        BYTE_ISSUE = ST_BYTE_ISSUE,
        BYTE_WAIT  = ST_BYTE_WAIT,
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
        CHK        = ST_CHK,
`endif
        DONE       = ST_DONE
    } state_e;

    // Payload words go out little-endian.
    function automatic logic [7:0] word_byte(logic [31:0] w, logic [1:0] idx);
        return w[idx*8 +: 8];
    endfunction

endpackage

// File: rtl/ft245_byte_issuer.sv
// Single-byte handshake with the FT245 port: one TX_EN strobe when the port is free,
// then hold TX_DATA until TX_DONE and report a one-cycle sent pulse.
module ft245_byte_issuer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    input  logic [7:0] byte_i,
    input  logic       tx_valid_i,
    input  logic       tx_done_i,
    output logic       tx_en_o,
    output logic [7:0] tx_data_o,
    output logic       sent_o
);

    logic       wait_q;
    logic       tx_en_q;
    logic [7:0] tx_data_q;
    logic       sent_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q    <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_data_q <= 8'h00;
            sent_q    <= 1'b0;
        end else begin
            tx_en_q <= 1'b0;
            sent_q  <= 1'b0;
            if (wait_q) begin
                if (tx_done_i) begin
                    wait_q <= 1'b0;
                    sent_q <= 1'b1;
                end
            // The requester still holds req_i during the sent cycle; skip it so a byte is not resent.
            end else if (req_i && !sent_q && !tx_valid_i) begin
                tx_en_q   <= 1'b1;
                tx_data_q <= byte_i;
                wait_q    <= 1'b1;
            end
        end
    end

    assign tx_en_o   = tx_en_q;
    assign tx_data_o = tx_data_q;
    assign sent_o    = sent_q;

endmodule

// File: rtl/ft245_tx_framer.sv
// Frames captured 32-bit words into an FT245 byte stream: sync, length, payload.
// Define FT245_TX_FRAMER_CHECKSUM_EN to append a two's-complement checksum byte.
module ft245_tx_framer
    import ft245_pkg::*;
#(
    parameter logic [7:0] HDR0 = DEF_HDR0,
    parameter logic [7:0] HDR1 = DEF_HDR1
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [11:0] WORD_COUNT,
    input  logic [31:0] WORD_DATA,
    input  logic        WORD_VALID,
    output logic        WORD_READY,
    output logic        TX_EN,
    output logic [7:0]  TX_DATA,
    input  logic        TX_VALID,
    input  logic        TX_DONE,
    output logic        BUSY,
    output logic        FRAME_DONE
);

    state_e      state_q;
    logic [1:0]  idx_q;
    logic [11:0] words_q;
    logic [31:0] word_q;
    logic        busy_q;
    logic        ready_q;
    logic        fdone_q;
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
    logic [7:0]  chk_q;
`endif

    logic       req;
    logic [7:0] cur_byte;
    logic       sent;

    // words_q still holds the full count while LEN is being sent.
    always_comb begin
        req      = 1'b0;
        cur_byte = 8'h00;
        case (state_q)
            HDR: begin
                req      = 1'b1;
                cur_byte = idx_q[0] ? HDR1 : HDR0;
            end
            LEN: begin
                req      = 1'b1;
                cur_byte = idx_q[0] ? {4'h0, words_q[11:8]} : words_q[7:0];
            end
            BYTE_ISSUE, BYTE_WAIT: begin
                req      = 1'b1;
                cur_byte = word_byte(word_q, idx_q);
            end
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
            CHK: begin
                req      = 1'b1;
                cur_byte = ~chk_q + 8'd1;
            end
`endif
            default: ;
        endcase
    end

    ft245_byte_issuer u_issuer (
        .clk        (CLK),
        .rst_n      (RST),
        .req_i      (req),
        .byte_i     (cur_byte),
        .tx_valid_i (TX_VALID),
        .tx_done_i  (TX_DONE),
        .tx_en_o    (TX_EN),
        .tx_data_o  (TX_DATA),
        .sent_o     (sent)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            words_q <= 12'd0;
            word_q  <= 32'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            fdone_q <= 1'b0;
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            fdone_q <= 1'b0;
            case (state_q)
                IDLE: if (START) begin
                    words_q <= WORD_COUNT;
                    idx_q   <= 2'd0;
                    busy_q  <= 1'b1;
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
                    chk_q   <= 8'h00;
`endif
                    state_q <= HDR;
                end
                HDR: if (sent) begin
                    idx_q <= idx_q[0] ? 2'd0 : 2'd1;
                    if (idx_q[0]) state_q <= LEN;
                end
                LEN: if (sent) begin
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
                    chk_q <= chk_q + cur_byte;
`endif
                    idx_q <= idx_q[0] ? 2'd0 : 2'd1;
                    if (idx_q[0]) begin
                        if (words_q != 12'd0) begin
                            state_q <= WORD_WAIT;
                            ready_q <= 1'b1;
                        end else begin
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
                            state_q <= CHK;
`else
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            fdone_q <= 1'b1;
`endif
                        end
                    end
                end
                WORD_WAIT: if (WORD_VALID && ready_q) begin
                    word_q  <= WORD_DATA;
                    words_q <= words_q - 12'd1;
                    ready_q <= 1'b0;
                    state_q <= BYTE_ISSUE;
                end
                BYTE_ISSUE: if (TX_EN) state_q <= BYTE_WAIT;
                BYTE_WAIT: if (sent) begin
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
                    chk_q <= chk_q + cur_byte;
`endif
                    idx_q <= idx_q + 2'd1;
                    if (idx_q != 2'd3) begin
                        state_q <= BYTE_ISSUE;
                    end else if (words_q != 12'd0) begin
                        state_q <= WORD_WAIT;
                        ready_q <= 1'b1;
                    end else begin
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
                        state_q <= CHK;
`else
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        fdone_q <= 1'b1;
`endif
                    end
                end
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
                CHK: if (sent) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    fdone_q <= 1'b1;
                end
`endif
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign WORD_READY = ready_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = fdone_q;

endmodule

// File: tb/tb_ft245_tx_framer.sv
// Randomized bench for ft245_tx_framer: FT245 port responder, word source and a
// byte-list frame model; directed cases cover stalls, ignored START and mid-frame reset.
module tb_ft245_tx_framer;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [11:0] WORD_COUNT = 12'd0;
    logic [31:0] WORD_DATA = 32'd0;
    logic        WORD_VALID = 1'b0;
    logic        WORD_READY;
    logic        TX_EN;
    logic [7:0]  TX_DATA;
    logic        TX_VALID = 1'b0;
    logic        TX_DONE = 1'b0;
    logic        BUSY;
    logic        FRAME_DONE;

    ft245_tx_framer dut (
        .CLK(CLK), .RST(RST), .START(START), .WORD_COUNT(WORD_COUNT),
        .WORD_DATA(WORD_DATA), .WORD_VALID(WORD_VALID), .WORD_READY(WORD_READY),
        .TX_EN(TX_EN), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID), .TX_DONE(TX_DONE),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_err = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    logic [31:0] wq[$];
    int  n_txen = 0, n_done = 0, n_fdone = 0;
    int  done_dly = 3, done_cnt = 0, tv_pct = 0, src_pct = 100;
    bit  rdy_seen = 1'b0, tv_force = 1'b0, src_en = 1'b1;
    bit  tv_prev = 1'b0, last_rdy = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        #1;
    endtask

    // Expected frame straight from the framing rules, using the words queued for the source.
    function automatic void build_exp(int cnt);
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'(cnt % 256));
        exp_q.push_back(8'(cnt / 256));
        foreach (wq[i])
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'((wq[i] >> (8 * b)) & 32'hFF));
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
        begin
            int s;
            s = 0;
            for (int i = 2; i < exp_q.size(); i++) s += int'(exp_q[i]);
            exp_q.push_back(8'((256 - s % 256) % 256));
        end
`endif
    endfunction

    // Environment: monitor, FT245 responder, TX_VALID driver and word source, all on negedge.
    initial begin
        forever begin
            @(negedge CLK);
            if (TX_EN) begin
                got_q.push_back(TX_DATA);
                n_txen++;
                chk("txen_while_full", {31'd0, tv_prev}, 32'd0);
            end
            if (FRAME_DONE) n_fdone++;
            if (WORD_READY) rdy_seen = 1'b1;
            TX_DONE = 1'b0;
            if (done_cnt > 0) begin
                done_cnt--;
                if (done_cnt == 0) begin TX_DONE = 1'b1; n_done++; end
            end
            if (TX_EN) begin
                if (done_dly == 0) begin TX_DONE = 1'b1; n_done++; end
                else done_cnt = done_dly;
            end
            TX_VALID = tv_force || ($urandom_range(0, 99) < tv_pct);
            tv_prev  = TX_VALID;
            if (WORD_VALID && last_rdy && wq.size() > 0) void'(wq.pop_front());
            WORD_VALID = 1'b0;
            if (src_en && wq.size() > 0 && $urandom_range(0, 99) < src_pct) begin
                WORD_VALID = 1'b1;
                WORD_DATA  = wq[0];
            end
            last_rdy = WORD_READY;
        end
    end

    task automatic start_frame(input int cnt);
        build_exp(cnt);
        got_q.delete();
        n_fdone  = 0;
        rdy_seen = 1'b0;
        WORD_COUNT = 12'(cnt);
        START = 1'b1;
        step();
        START = 1'b0;
        chk("busy_after_start", {31'd0, BUSY}, 32'd1);
    endtask

    task automatic finish_frame(input int budget);
        int t;
        t = 0;
        while (n_fdone == 0 && t < budget) begin step(); t++; end
        chk("frame_done_timeout", {31'd0, n_fdone != 0}, 32'd1);
        if (n_fdone != 0) begin
            chk("busy_at_done", {31'd0, BUSY}, 32'd0);
            chk("fdone_level", {31'd0, FRAME_DONE}, 32'd1);
        end
        step();
        chk("fdone_one_cycle", {31'd0, FRAME_DONE}, 32'd0);
        step();
        chk("fdone_count", n_fdone, 32'd1);
        chk("nbytes", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            chk($sformatf("byte[%0d]", i), {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        chk("words_left", wq.size(), 32'd0);
    endtask

    task automatic fill_words(input int cnt);
        wq.delete();
        for (int i = 0; i < cnt; i++) wq.push_back($urandom);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_txen"}, {31'd0, TX_EN}, 32'd0);
        chk({tag, "_txdata"}, {24'd0, TX_DATA}, 32'd0);
        chk({tag, "_wready"}, {31'd0, WORD_READY}, 32'd0);
        chk({tag, "_busy"}, {31'd0, BUSY}, 32'd0);
        chk({tag, "_fdone"}, {31'd0, FRAME_DONE}, 32'd0);
    endtask

    initial begin
        int base, t;
        bit ok;
        repeat (3) step();
        check_idle_outputs("reset");
        RST = 1'b1;
        step();

        // Reference frame with fixed words, TX_DONE three cycles after TX_EN.
        wq.delete();
        wq.push_back(32'h04030201);
        wq.push_back(32'h08070605);
        start_frame(2);
        finish_frame(2000);
`ifdef FT245_TX_FRAMER_CHECKSUM_EN
        chk("basic_chk_DA", got_q.size() > 12 ? {24'd0, got_q[12]} : 32'hFFFF, 32'hDA);
`endif

        // Empty payload.
        wq.delete();
        start_frame(0);
        finish_frame(1000);
        chk("zero_ready_never", {31'd0, rdy_seen}, 32'd0);

        // Port full for 50 cycles before the second byte.
        wq.delete();
        start_frame(0);
        t = 0;
        while (got_q.size() < 1 && t < 200) begin step(); t++; end
        chk("stall_first_byte", got_q.size(), 32'd1);
        tv_force = 1'b1;
        base = n_txen;
        repeat (50) step();
        chk("stall_no_txen", n_txen, base);
        tv_force = 1'b0;
        step();
        chk("stall_release_no_txen_yet", {31'd0, TX_EN}, 32'd0);
        step();
        chk("stall_txen", {31'd0, TX_EN}, 32'd1);
        chk("stall_byte", {24'd0, TX_DATA}, 32'h5A);
        finish_frame(1000);

        // Source stalls in WORD_WAIT for 20 cycles.
        fill_words(1);
        src_en = 1'b0;
        start_frame(1);
        t = 0;
        while (!WORD_READY && t < 500) begin step(); t++; end
        chk("ws_ready_seen", {31'd0, WORD_READY}, 32'd1);
        base = n_txen;
        ok = 1'b1;
        repeat (20) begin step(); if (!WORD_READY) ok = 1'b0; end
        chk("ws_ready_held", {31'd0, ok}, 32'd1);
        chk("ws_no_txen", n_txen, base);
        src_en = 1'b1;
        step();
        chk("ws_handshake", {31'd0, WORD_VALID & WORD_READY}, 32'd1);
        step();
        chk("ws_ready_drop", {31'd0, WORD_READY}, 32'd0);
        finish_frame(1000);

        // START while busy must be ignored.
        fill_words(3);
        start_frame(3);
        t = 0;
        while (got_q.size() < 3 && t < 500) begin step(); t++; end
        WORD_COUNT = 12'd1;
        START = 1'b1;
        step();
        START = 1'b0;
        finish_frame(2000);

        // Reset after the sixth TX_DONE abandons the frame.
        fill_words(2);
        base = n_done;
        start_frame(2);
        t = 0;
        while (n_done < base + 6 && t < 1000) begin step(); t++; end
        chk("rst_six_done", n_done - base, 32'd6);
        step();
        RST = 1'b0;
        #1;
        check_idle_outputs("midreset");
        wq.delete();
        repeat (3) step();
        RST = 1'b1;
        base = n_txen;
        repeat (20) step();
        chk("no_txen_after_reset", n_txen, base);
        fill_words(1);
        start_frame(1);
        finish_frame(1000);
        chk("fresh_first_A5", got_q.size() > 0 ? {24'd0, got_q[0]} : 32'hFFFF, 32'hA5);

        // Random frames with random port latency, port stalls and source gaps.
        for (int n = 0; n < 20; n++) begin
            int cnt;
            cnt      = $urandom_range(0, 8);
            done_dly = $urandom_range(0, 4);
            tv_pct   = $urandom_range(0, 30);
            src_pct  = $urandom_range(20, 100);
            fill_words(cnt);
            start_frame(cnt);
            finish_frame(4000);
            repeat ($urandom_range(0, 3)) step();
        end

        // Maximum count: exactly 4095 words, no counter wrap.
        done_dly = 0;
        tv_pct   = 0;
        src_pct  = 100;
        fill_words(4095);
        start_frame(4095);
        finish_frame(80000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
